frame_filler: RTL



---
 rtl/frame_filler.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/frame_filler.sv
// frame_filler: forces every DVP line to H_DISP pixels and every frame to V_DISP lines, padding with fill_color
module frame_filler #(
  parameter int DATA_W = 24,
  parameter int H_DISP = 1280,
  parameter int V_DISP = 720,
  parameter int H_GAP  = 16,
  parameter int CNT_W  = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] fill_color,
  input  logic              pre_vs,
  input  logic              pre_de,
  input  logic [DATA_W-1:0] pre_data,
  output logic              post_vs,
  output logic              post_de,
  output logic [DATA_W-1:0] post_data,
  output logic              stat_hfill,
  output logic              stat_vfill,
  output logic              err_drop
);
  localparam logic [CNT_W-1:0] H_MAX = CNT_W'(H_DISP);
  localparam logic [CNT_W-1:0] V_MAX = CNT_W'(V_DISP);
  localparam logic [CNT_W-1:0] G_MAX = CNT_W'(H_GAP);
  typedef enum logic [2:0] {IDLE, RECV, HFILL, VFILL_GAP, VFILL_LINE} state_t;
  state_t state, state_n;
  logic [CNT_W-1:0] px_cnt, px_n, line_cnt, line_n, px_inc, line_inc;
  logic vs_q, vs_pend, pend_n, vs_rise, vs_ev, over;
  logic vs_n, de_n, hfill_n, vfill_n, err_n;
  logic [DATA_W-1:0] data_n;
  assign vs_rise  = pre_vs & ~vs_q;
  assign vs_ev    = vs_rise | vs_pend;
  assign over     = line_cnt >= V_MAX;
  assign px_inc   = px_cnt + 1'b1;
  assign line_inc = over ? V_MAX : line_cnt + 1'b1;
  // vs_pend holds a vsync seen while a line or vertical fill is still running
  always_comb begin
    state_n = state;
    px_n    = px_cnt;
    line_n  = line_cnt;
    pend_n  = vs_ev;
    vs_n    = 1'b0;
    de_n    = 1'b0;
    data_n  = '0;
    hfill_n = 1'b0;
    vfill_n = 1'b0;
    err_n   = err_drop;
    if (!en) begin
      state_n = IDLE;
      px_n    = '0;
      line_n  = '0;
      pend_n  = 1'b0;
      vs_n    = pre_vs;
      de_n    = pre_de;
      data_n  = pre_data;
    end else begin
      case (state)
        IDLE: begin
          px_n = '0;
          if (vs_ev && line_cnt != '0 && !over) begin
            state_n = VFILL_GAP;
            pend_n  = 1'b1;
            err_n   = err_drop | pre_de;
          end else begin
            line_n = vs_ev ? '0 : line_cnt;
            pend_n = 1'b0;
            vs_n   = pre_vs | vs_pend;
            de_n   = pre_de & (vs_ev | ~over);
            data_n = de_n ? pre_data : '0;
            state_n = pre_de ? RECV : IDLE;
            px_n    = pre_de ? CNT_W'(1) : '0;
          end
        end
        RECV: begin
          if (pre_de) begin
            de_n   = (px_cnt < H_MAX) && !over;
            data_n = de_n ? pre_data : '0;
            px_n   = (px_cnt < H_MAX) ? px_inc : px_cnt;
          end else if (px_cnt < H_MAX && !over) begin
            de_n    = 1'b1;
            data_n  = fill_color;
            px_n    = px_inc;
            hfill_n = px_inc >= H_MAX;
            state_n = hfill_n ? IDLE : HFILL;
            line_n  = hfill_n ? line_inc : line_cnt;
          end else begin
            state_n = IDLE;
            line_n  = line_inc;
          end
        end
        HFILL: begin
          de_n    = 1'b1;
          data_n  = fill_color;
          px_n    = px_inc;
          err_n   = err_drop | pre_de;
          hfill_n = px_inc >= H_MAX;
          state_n = hfill_n ? IDLE : HFILL;
          line_n  = hfill_n ? line_inc : line_cnt;
        end
        VFILL_GAP: begin
          err_n   = err_drop | pre_de;
          state_n = (px_inc >= G_MAX) ? VFILL_LINE : VFILL_GAP;
          px_n    = (px_inc >= G_MAX) ? '0 : px_inc;
        end
        VFILL_LINE: begin
          de_n   = 1'b1;
          data_n = fill_color;
          err_n  = err_drop | pre_de;
          px_n   = px_inc;
          if (px_inc >= H_MAX) begin
            px_n    = '0;
            vfill_n = line_inc >= V_MAX;
            line_n  = vfill_n ? '0 : line_inc;
            state_n = vfill_n ? IDLE : VFILL_GAP;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      px_cnt     <= '0;
      line_cnt   <= '0;
      vs_q       <= 1'b0;
      vs_pend    <= 1'b0;
      post_vs    <= 1'b0;
      post_de    <= 1'b0;
      post_data  <= '0;
      stat_hfill <= 1'b0;
      stat_vfill <= 1'b0;
      err_drop   <= 1'b0;
    end else begin
      state      <= state_n;
      px_cnt     <= px_n;
      line_cnt   <= line_n;
      vs_q       <= pre_vs;
      vs_pend    <= pend_n;
      post_vs    <= vs_n;
      post_de    <= de_n;
      post_data  <= data_n;
      stat_hfill <= hfill_n;
      stat_vfill <= vfill_n;
      err_drop   <= err_n;
    end
  end
endmodule
